// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared types and widths for the fetch/decode to dispatch path
// Contents: field widths, fetch width, and the decoded instruction record stored by instr_buffer.
package instr_pkg;

    localparam int OPCODE_W  = 4;
    localparam int REG_W     = 4;
    localparam int ROB_TAG_W = 4;
    localparam int FETCH_W   = 4;

    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;
        logic                 a_dep;
        logic [ROB_TAG_W-1:0] a_owner;
        logic                 b_dep;
        logic [ROB_TAG_W-1:0] b_owner;
        logic [REG_W-1:0]     rt;
        logic [REG_W-1:0]     ra;
        logic [REG_W-1:0]     rb;
    } decoded_instr_t;

endpackage

// File: rtl/instr_buffer.sv
// rtl/instr_buffer.sv - in-order multi-lane instruction FIFO between fetch and dispatch
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_count, in_*        up to FETCH_W decoded instructions per cycle (lanes 0..in_count-1)
//   is_jump               flush: empties the buffer, discards same-cycle traffic
//   num_fetch             free slots offered to fetch, min(DEPTH-count, FETCH_W)
//   out_valid, out_*      oldest DISP_W entries, lane 0 oldest, combinational read
//   deq_count             entries taken by dispatch this cycle
//   count                 current occupancy
// Optional (INSTR_BUFFER_STATS_EN): full_stall_cycles, high_water.
module instr_buffer #(
    parameter int DEPTH   = 16,
    parameter int FETCH_W = 4,
    parameter int DISP_W  = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [2:0]                                    in_count,
    input  logic [FETCH_W*instr_pkg::OPCODE_W-1:0]        in_opcode,
    input  logic [FETCH_W-1:0]                            in_a_dep,
    input  logic [FETCH_W*instr_pkg::ROB_TAG_W-1:0]       in_a_owner,
    input  logic [FETCH_W-1:0]                            in_b_dep,
    input  logic [FETCH_W*instr_pkg::ROB_TAG_W-1:0]       in_b_owner,
    input  logic [FETCH_W*instr_pkg::REG_W-1:0]           in_rt,
    input  logic [FETCH_W*instr_pkg::REG_W-1:0]           in_ra,
    input  logic [FETCH_W*instr_pkg::REG_W-1:0]           in_rb,
    input  logic                                          is_jump,
    output logic [2:0]                                    num_fetch,
    output logic [DISP_W-1:0]                             out_valid,
    output logic [DISP_W*instr_pkg::OPCODE_W-1:0]         out_opcode,
    output logic [DISP_W-1:0]                             out_a_dep,
    output logic [DISP_W*instr_pkg::ROB_TAG_W-1:0]        out_a_owner,
    output logic [DISP_W-1:0]                             out_b_dep,
    output logic [DISP_W*instr_pkg::ROB_TAG_W-1:0]        out_b_owner,
    output logic [DISP_W*instr_pkg::REG_W-1:0]            out_rt,
    output logic [DISP_W*instr_pkg::REG_W-1:0]            out_ra,
    output logic [DISP_W*instr_pkg::REG_W-1:0]            out_rb,
    input  logic [1:0]                                    deq_count,
    output logic [$clog2(DEPTH):0]                        count
`ifdef INSTR_BUFFER_STATS_EN
   ,output logic [15:0]                                   full_stall_cycles,
    output logic [$clog2(DEPTH):0]                        high_water
`endif
);
    import instr_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    decoded_instr_t mem_q [DEPTH];
    ptr_t           head_q, head_d, tail_q, tail_d;
    cnt_t           count_q, count_d;

    decoded_instr_t lane_in [FETCH_W];
    decoded_instr_t rd_lane [DISP_W];
    logic [2:0]     enq_acc;
    cnt_t           deq_acc;
    cnt_t           free_slots;

    always_comb begin
        for (int k = 0; k < FETCH_W; k++) begin
            lane_in[k].opcode  = in_opcode[k*OPCODE_W +: OPCODE_W];
            lane_in[k].a_dep   = in_a_dep[k];
            lane_in[k].a_owner = in_a_owner[k*ROB_TAG_W +: ROB_TAG_W];
            lane_in[k].b_dep   = in_b_dep[k];
            lane_in[k].b_owner = in_b_owner[k*ROB_TAG_W +: ROB_TAG_W];
            lane_in[k].rt      = in_rt[k*REG_W +: REG_W];
            lane_in[k].ra      = in_ra[k*REG_W +: REG_W];
            lane_in[k].rb      = in_rb[k*REG_W +: REG_W];
        end
    end

    // Credit is based on registered occupancy only; slots freed by a
    // same-cycle dequeue become visible to fetch one cycle later.
    always_comb begin
        free_slots = cnt_t'(DEPTH) - count_q;
        num_fetch  = (free_slots >= cnt_t'(FETCH_W)) ? 3'(FETCH_W) : free_slots[2:0];
        enq_acc    = (in_count < num_fetch) ? in_count : num_fetch;
        deq_acc    = cnt_t'(deq_count);
        if (deq_acc > count_q)         deq_acc = count_q;
        if (deq_acc > cnt_t'(DISP_W))  deq_acc = cnt_t'(DISP_W);
    end

    always_comb begin
        head_d  = head_q + ptr_t'(deq_acc);
        tail_d  = tail_q + ptr_t'(enq_acc);
        count_d = count_q + cnt_t'(enq_acc) - deq_acc;
        if (is_jump) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately not reset; validity comes from count_q alone.
    always_ff @(posedge clk) begin
        if (!is_jump) begin
            for (int k = 0; k < FETCH_W; k++) begin
                if (3'(k) < enq_acc) begin
                    mem_q[tail_q + ptr_t'(k)] <= lane_in[k];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < DISP_W; k++) begin
            rd_lane[k]                            = mem_q[head_q + ptr_t'(k)];
            out_valid[k]                          = (count_q > cnt_t'(k));
            out_opcode[k*OPCODE_W +: OPCODE_W]    = rd_lane[k].opcode;
            out_a_dep[k]                          = rd_lane[k].a_dep;
            out_a_owner[k*ROB_TAG_W +: ROB_TAG_W] = rd_lane[k].a_owner;
            out_b_dep[k]                          = rd_lane[k].b_dep;
            out_b_owner[k*ROB_TAG_W +: ROB_TAG_W] = rd_lane[k].b_owner;
            out_rt[k*REG_W +: REG_W]              = rd_lane[k].rt;
            out_ra[k*REG_W +: REG_W]              = rd_lane[k].ra;
            out_rb[k*REG_W +: REG_W]              = rd_lane[k].rb;
        end
    end

    assign count = count_q;

`ifdef INSTR_BUFFER_STATS_EN
    logic [15:0] stall_q, stall_d;
    cnt_t        hw_q, hw_d;

    // Statistics survive flushes; only reset clears them.
    always_comb begin
        stall_d = stall_q;
        if (count_q == cnt_t'(DEPTH) && in_count != 3'd0 && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
        hw_d = (count_d > hw_q) ? count_d : hw_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            hw_q    <= '0;
        end else begin
            stall_q <= stall_d;
            hw_q    <= hw_d;
        end
    end

    assign full_stall_cycles = stall_q;
    assign high_water        = hw_q;
`endif

endmodule
